// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: accepts a WIDTH-bit operand pair and adds it one
// 4-bit nibble per clock (LSB first) through a single carry flop, then holds
// the WIDTH-bit sum and carry-out on a valid/ready result port.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    base;
  logic [4:0]       nsum;
  logic             last;

  // One slice of the 4-bit ripple adder: 5-bit result holds the nibble carry.
  function automatic logic [4:0] nib_add(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       ci);
    return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

  assign base = {idx, 2'b00};
  assign last = (idx == IW'(NIB - 1));
  assign nsum = nib_add(a_reg[base +: 4], b_reg[base +: 4], carry);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode; handshake outputs depend on state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-nibble sum/carry update and final carry-out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          sum[base +: 4] <= nsum[3:0];
          carry          <= nsum[4];
          if (last) begin
            cout <= nsum[4];
            idx  <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: 16-bit and 4-bit instances.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  logic        in_valid4;
  logic        in_ready4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        out_valid4;
  logic        out_ready4;
  logic [3:0]  sum4;
  logic        cout4;
  logic        busy4;

  int total;
  int bad;
  int cyc;
  int last_cyc;
  int n;

  logic [15:0] bav [3];
  logic [15:0] bbv [3];
  logic [15:0] bsv [3];
  logic        bcv [3];

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one pair, check latency, result, and return to IDLE.
  task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] es, input logic ec);
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk({tag, "_rdy_run"}, in_ready, 1'b0);
    chk({tag, "_busy_run"}, busy, 1'b1);
    step(); step(); step();
    chk({tag, "_vld_early"}, out_valid, 1'b0);
    step();
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_vld"}, out_valid, 1'b0);
    chk({tag, "_idle_rdy"}, in_ready, 1'b1);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; last_cyc = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
    bav[0] = 16'hBEEF; bbv[0] = 16'h1234; bsv[0] = 16'hD123; bcv[0] = 1'b0;
    bav[1] = 16'hC0DE; bbv[1] = 16'h5A5A; bsv[1] = 16'h1B38; bcv[1] = 1'b1;
    bav[2] = 16'h7FFF; bbv[2] = 16'h7FFF; bsv[2] = 16'hFFFE; bcv[2] = 1'b0;

    step(); step();
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    rst_n = 1'b1;
    step();

    do_op("basic", 16'h1234, 16'h4321, 16'h5555, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    do_op("msb", 16'h8000, 16'h8000, 16'h0000, 1'b1);

    // Backpressure: stall in DONE for 5 cycles with ignored in_valid pulses.
    a = 16'h00FF; b = 16'h0F01; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    chk("bp_vld", out_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      a = 16'hAAAA; b = 16'hAAAA; in_valid = (k % 2) == 0;
      step();
      chk("bp_hold_vld", out_valid, 1'b1);
      chk("bp_hold_sum", sum, 16'h1000);
      chk("bp_hold_cout", cout, 1'b0);
      chk("bp_hold_rdy", in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_vld", out_valid, 1'b0);
    chk("bp_idle_rdy", in_ready, 1'b1);
    chk("bp_retain_sum", sum, 16'h1000);

    // Reset after two nibble steps aborts the operation.
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_vld", out_valid, 1'b0);
    chk("mid_rst_rdy", in_ready, 1'b1);
    chk("mid_rst_sum", sum, 16'h0000);
    chk("mid_rst_cout", cout, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    step();
    chk("post_rst_vld", out_valid, 1'b0);
    do_op("after_rst", 16'h0001, 16'h0001, 16'h0002, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    a = bav[0]; b = bbv[0]; in_valid = 1'b1; out_ready = 1'b1;
    step();
    a = bav[1]; b = bbv[1];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!out_valid && n < 20) begin
        step();
        n = n + 1;
      end
      chk("b2b_vld", out_valid, 1'b1);
      chk("b2b_sum", sum, bsv[k]);
      chk("b2b_cout", cout, bcv[k]);
      if (k > 0) chk("b2b_gap", cyc - last_cyc, 6);
      last_cyc = cyc;
      step(); step();
      if (k < 1) begin
        a = bav[k + 2]; b = bbv[k + 2];
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    out_ready = 1'b0;
    chk("b2b_drain_rdy", in_ready, 1'b1);

    // Single-nibble instance: RUN lasts one cycle.
    chk("w4_rst_rdy", in_ready4, 1'b1);
    a4 = 4'h9; b4 = 4'h8; in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    chk("w4_busy", busy4, 1'b1);
    chk("w4_vld_early", out_valid4, 1'b0);
    step();
    chk("w4_vld", out_valid4, 1'b1);
    chk("w4_sum", sum4, 4'h1);
    chk("w4_cout", cout4, 1'b1);
    out_ready4 = 1'b1;
    step();
    out_ready4 = 1'b0;
    chk("w4_idle_rdy", in_ready4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
